// File: rtl/seg7_pkg.sv
// Shared definitions for the multiplexed seven-segment display: segment
// patterns (a..g in bits 0..6, active-high), converter states, and helpers.
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [6:0] SEG_DASH  = 7'b1000000;
    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;

    typedef enum logic [1:0] {
        CONV_IDLE,
        CONV_SHIFT,
        CONV_DONE
    } convState_t;

    // Enough BCD digits to hold any BIN_W-bit value, and never fewer than
    // the number of display digits.
    function automatic int seg7_nbcd(input int binW, input int digits);
        int needed;
        needed = (binW + 2) / 3;
        return (digits > needed) ? digits : needed;
    endfunction

    // Codes 10..15 are unreachable from the converter and map to blank.
    function automatic logic [6:0] seg7_decode(input logic [3:0] bcd);
        case (bcd)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one shift-add-3 step per clock.
// Ready is low while shifting; the done cycle presents the final BCD and
// also accepts the next value, so back-to-back conversions lose no cycle.
module bin2bcd_seq
    import seg7_pkg::*;
#(
    parameter int BIN_W = 8,
    parameter int NBCD  = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_valid,
    input  logic [BIN_W-1:0]    i_binary,
    output logic                o_ready,
    output logic                o_done,
    output logic [NBCD*4-1:0]   o_bcd
);

    localparam int CNT_W = $clog2(BIN_W + 1);

    convState_t          r_state;
    convState_t          w_nextState;
    logic [BIN_W-1:0]    r_bin;
    logic [NBCD*4-1:0]   r_bcd;
    logic [NBCD*4-1:0]   w_adjusted;
    logic [NBCD*4-1:0]   w_shifted;
    logic [CNT_W-1:0]    r_cnt;
    logic                w_accept;
    logic                w_lastShift;

    assign o_bcd = r_bcd;

    // Converter state register; reset abandons any conversion in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= CONV_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next state plus handshake outputs; accept is possible in idle and done.
    always_comb begin
        w_nextState = r_state;
        o_ready     = 1'b0;
        o_done      = 1'b0;
        w_accept    = 1'b0;
        w_lastShift = (r_cnt == CNT_W'(BIN_W - 1));
        case (r_state)
            CONV_IDLE: begin
                o_ready = 1'b1;
                if (i_valid) begin
                    w_accept    = 1'b1;
                    w_nextState = CONV_SHIFT;
                end
            end
            CONV_SHIFT: begin
                if (w_lastShift) begin
                    w_nextState = CONV_DONE;
                end
            end
            CONV_DONE: begin
                o_ready = 1'b1;
                o_done  = 1'b1;
                if (i_valid) begin
                    w_accept    = 1'b1;
                    w_nextState = CONV_SHIFT;
                end else begin
                    w_nextState = CONV_IDLE;
                end
            end
            default: begin
                w_nextState = CONV_IDLE;
            end
        endcase
    end

    // One double-dabble step: add 3 to every digit >= 5, then shift in the
    // next binary MSB.
    always_comb begin
        w_adjusted = r_bcd;
        for (int d = 0; d < NBCD; d++) begin
            if (r_bcd[d*4 +: 4] >= 4'd5) begin
                w_adjusted[d*4 +: 4] = r_bcd[d*4 +: 4] + 4'd3;
            end
        end
        w_shifted = {w_adjusted[NBCD*4-2:0], r_bin[BIN_W-1]};
    end

    // Datapath: capture on accept, otherwise shift while converting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bin <= '0;
            r_bcd <= '0;
            r_cnt <= '0;
        end else if (w_accept) begin
            r_bin <= i_binary;
            r_bcd <= '0;
            r_cnt <= '0;
        end else if (r_state == CONV_SHIFT) begin
            r_bin <= r_bin << 1;
            r_bcd <= w_shifted;
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/seven_seg_scan_n.sv
// Multiplexed seven-segment driver: converts a binary value to BCD, holds
// it in a display register, and scans the digits with a prescaled index.
module seven_seg_scan_n
    import seg7_pkg::*;
#(
    parameter int BIN_W    = 8,
    parameter int DIGITS   = 3,
    parameter int PRESCALE = 131072,
    parameter int BLANK_LZ = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [BIN_W-1:0]    binary,
    input  logic                bin_valid,
    output logic                bin_ready,
    output logic [6:0]          seg,
    output logic [DIGITS-1:0]   ca,
    output logic                overflow
);

    localparam int NBCD  = seg7_nbcd(BIN_W, DIGITS);
    localparam int PRE_W = $clog2(PRESCALE);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic                  w_done;
    logic [NBCD*4-1:0]     w_bcd;
    logic                  w_bcdOvf;
    logic                  w_tick;
    logic [PRE_W-1:0]      r_pre;
    logic [IDX_W-1:0]      r_idx;
    logic [DIGITS*4-1:0]   r_disp;
    logic                  r_ovf;
    logic [3:0]            w_digit;
    logic                  w_nonzeroAbove;
    logic [6:0]            w_segNext;
    logic [DIGITS-1:0]     w_caNext;
    logic [6:0]            r_seg;
    logic [DIGITS-1:0]     r_ca;

    bin2bcd_seq #(
        .BIN_W (BIN_W),
        .NBCD  (NBCD)
    ) u_conv (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_valid  (bin_valid),
        .i_binary (binary),
        .o_ready  (bin_ready),
        .o_done   (w_done),
        .o_bcd    (w_bcd)
    );

    assign seg      = r_seg;
    assign ca       = r_ca;
    assign overflow = r_ovf;
    assign w_tick   = (r_pre == PRE_W'(PRESCALE - 1));

    // Any nonzero BCD digit beyond the display width means overflow.
    always_comb begin
        w_bcdOvf = 1'b0;
        for (int d = DIGITS; d < NBCD; d++) begin
            if (w_bcd[d*4 +: 4] != 4'd0) begin
                w_bcdOvf = 1'b1;
            end
        end
    end

    // Prescaler and digit index; the index steps on prescaler terminal count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre <= '0;
            r_idx <= '0;
        end else if (w_tick) begin
            r_pre <= '0;
            r_idx <= (r_idx == IDX_W'(DIGITS - 1)) ? '0 : r_idx + IDX_W'(1);
        end else begin
            r_pre <= r_pre + PRE_W'(1);
        end
    end

    // Display register loads every digit at once when a conversion finishes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_disp <= '0;
            r_ovf  <= 1'b0;
        end else if (w_done) begin
            r_disp <= w_bcd[DIGITS*4-1:0];
            r_ovf  <= w_bcdOvf;
        end
    end

    // Select the active digit, apply overflow dash and leading-zero blanking.
    always_comb begin
        w_digit        = 4'd0;
        w_nonzeroAbove = 1'b0;
        for (int j = 0; j < DIGITS; j++) begin
            if (IDX_W'(j) == r_idx) begin
                w_digit = r_disp[j*4 +: 4];
            end
            if (IDX_W'(j) >= r_idx && r_disp[j*4 +: 4] != 4'd0) begin
                w_nonzeroAbove = 1'b1;
            end
        end
        if (r_ovf) begin
            w_segNext = SEG_DASH;
        end else if (BLANK_LZ != 0 && r_idx != '0 && !w_nonzeroAbove) begin
            w_segNext = SEG_BLANK;
        end else begin
            w_segNext = seg7_decode(w_digit);
        end
        w_caNext = ~(DIGITS'(1) << r_idx);
    end

    // Registered outputs so segment and anode always change together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg <= SEG_BLANK;
            r_ca  <= '1;
        end else begin
            r_seg <= w_segNext;
            r_ca  <= w_caNext;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_n.sv
// Bench for seven_seg_scan_n: four instances sharing one input stream
// (blanking on/off, two digits for overflow, four digits for scan timing).
module tb_seven_seg_scan_n;

    logic       clk;
    logic       rst_n;
    logic [7:0] binary;
    logic       binValid;

    logic       readyA, readyB, readyC, readyD;
    logic [6:0] segA, segB, segC, segD;
    logic [2:0] caA, caB;
    logic [1:0] caC;
    logic [3:0] caD;
    logic       ovfA, ovfB, ovfC, ovfD;

    int checks = 0;
    int errors = 0;
    int sb[$];

    seven_seg_scan_n #(.BIN_W(8), .DIGITS(3), .PRESCALE(4), .BLANK_LZ(1)) dutA (
        .clk(clk), .rst_n(rst_n), .binary(binary), .bin_valid(binValid),
        .bin_ready(readyA), .seg(segA), .ca(caA), .overflow(ovfA));

    seven_seg_scan_n #(.BIN_W(8), .DIGITS(3), .PRESCALE(4), .BLANK_LZ(0)) dutB (
        .clk(clk), .rst_n(rst_n), .binary(binary), .bin_valid(binValid),
        .bin_ready(readyB), .seg(segB), .ca(caB), .overflow(ovfB));

    seven_seg_scan_n #(.BIN_W(8), .DIGITS(2), .PRESCALE(4), .BLANK_LZ(1)) dutC (
        .clk(clk), .rst_n(rst_n), .binary(binary), .bin_valid(binValid),
        .bin_ready(readyC), .seg(segC), .ca(caC), .overflow(ovfC));

    seven_seg_scan_n #(.BIN_W(8), .DIGITS(4), .PRESCALE(4), .BLANK_LZ(1)) dutD (
        .clk(clk), .rst_n(rst_n), .binary(binary), .bin_valid(binValid),
        .bin_ready(readyD), .seg(segD), .ca(caD), .overflow(ovfD));

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Absolute time limit so a stuck handshake cannot hang the run
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [7:0] getCa(input int w);
        case (w)
            0:       return {5'b0, caA};
            1:       return {5'b0, caB};
            2:       return {6'b0, caC};
            default: return {4'b0, caD};
        endcase
    endfunction

    function automatic logic [6:0] getSeg(input int w);
        case (w)
            0:       return segA;
            1:       return segB;
            2:       return segC;
            default: return segD;
        endcase
    endfunction

    function automatic logic getOvf(input int w);
        case (w)
            0:       return ovfA;
            1:       return ovfB;
            2:       return ovfC;
            default: return ovfD;
        endcase
    endfunction

    function automatic logic getReady(input int w);
        case (w)
            0:       return readyA;
            1:       return readyB;
            2:       return readyC;
            default: return readyD;
        endcase
    endfunction

    function automatic int digitsOf(input int w);
        case (w)
            0:       return 3;
            1:       return 3;
            2:       return 2;
            default: return 4;
        endcase
    endfunction

    function automatic int blankOf(input int w);
        return (w == 1) ? 0 : 1;
    endfunction

    function automatic int caMask(input int d, input int k);
        return ((1 << d) - 1) & ~(1 << k);
    endfunction

    function automatic int pow10(input int n);
        int p;
        p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    function automatic logic [6:0] digitPattern(input int d);
        case (d)
            0:       return 7'h3F;
            1:       return 7'h06;
            2:       return 7'h5B;
            3:       return 7'h4F;
            4:       return 7'h66;
            5:       return 7'h6D;
            6:       return 7'h7D;
            7:       return 7'h07;
            8:       return 7'h7F;
            default: return 7'h6F;
        endcase
    endfunction

    // Reference model: decimal arithmetic on the value, not BCD shifting
    function automatic logic [6:0] expSeg(input int value, input int digits, input int blank, input int k);
        if (value >= pow10(digits)) return 7'h40;
        if (blank != 0 && k > 0 && value < pow10(k)) return 7'h00;
        return digitPattern((value / pow10(k)) % 10);
    endfunction

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkResetState(input string tag);
        for (int w = 0; w < 4; w++) begin
            check($sformatf("%s dut%0d seg", tag, w), 32'(getSeg(w)), 0);
            check($sformatf("%s dut%0d ca", tag, w), 32'(getCa(w)), (1 << digitsOf(w)) - 1);
            check($sformatf("%s dut%0d ovf", tag, w), 32'(getOvf(w)), 0);
            check($sformatf("%s dut%0d ready", tag, w), 32'(getReady(w)), 1);
        end
    endtask

    // Walk every digit position of one instance and compare with the model
    task automatic checkScan(input int w, input int value);
        int d;
        int n;
        d = digitsOf(w);
        for (int k = 0; k < d; k++) begin
            n = 0;
            while (int'(getCa(w)) != caMask(d, k) && n < 64) begin
                @(negedge clk);
                n++;
            end
            check($sformatf("dut%0d v%0d digit%0d reached", w, value, k), 32'(n < 64), 1);
            check($sformatf("dut%0d v%0d digit%0d seg", w, value, k), 32'(getSeg(w)),
                  32'(expSeg(value, d, blankOf(w), k)));
            check($sformatf("dut%0d v%0d ovf", w, value), 32'(getOvf(w)),
                  32'(value >= pow10(d)));
        end
    endtask

    // Compare only the digit currently lit on one instance
    task automatic checkNow(input int w, input int value);
        int d;
        int found;
        d = digitsOf(w);
        found = 0;
        for (int k = 0; k < d; k++) begin
            if (int'(getCa(w)) == caMask(d, k)) begin
                found = 1;
                check($sformatf("dut%0d now v%0d digit%0d seg", w, value, k), 32'(getSeg(w)),
                      32'(expSeg(value, d, blankOf(w), k)));
            end
        end
        check($sformatf("dut%0d now onehot", w), 32'(found), 1);
    endtask

    // Offer a value, push its expectation, then count the busy cycles
    task automatic applyStimulus(input logic [7:0] v);
        int n;
        n = 0;
        while (!readyA && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("ready before send", 32'(readyA), 1);
        binary   = v;
        binValid = 1'b1;
        @(posedge clk);
        sb.push_back(int'(v));
        #1 binValid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!readyA && n < 50) begin
            n++;
            @(negedge clk);
        end
        check($sformatf("ready low cycles v%0d", v), n, 8);
    endtask

    // Commit edge, one more edge for the registered outputs, then scan all
    task automatic checkOutput();
        int v;
        check("scoreboard nonempty", 32'(sb.size() != 0), 1);
        v = (sb.size() != 0) ? sb.pop_front() : -1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        for (int w = 0; w < 4; w++) checkScan(w, v);
    endtask

    initial begin
        int n;
        int hold;
        int v;
        logic [3:0] prevCa;
        logic [3:0] curCa;
        int prevIdx;

        rst_n    = 1'b0;
        binValid = 1'b0;
        binary   = 8'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkResetState("reset");

        // Release reset; digit 0 must show '0'
        rst_n = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("post reset caA", 32'(caA), 32'h6);
        check("post reset segA", 32'(segA), 32'h3F);
        check("post reset caD", 32'(caD), 32'hE);

        // Three-digit value, overflow on the two-digit instance
        applyStimulus(8'd207);
        checkOutput();

        // Leading-zero blanking versus zeros shown
        applyStimulus(8'd5);
        checkOutput();

        // All 8-bit ones: two-digit instance shows dashes
        applyStimulus(8'd255);
        checkOutput();

        applyStimulus(8'd42);
        checkOutput();

        // bin_valid held high with binary changing during conversion
        binary   = 8'd123;
        binValid = 1'b1;
        @(posedge clk);
        sb.push_back(123);
        #1 binary = 8'd200;
        n = 0;
        @(negedge clk);
        while (!readyA && n < 50) begin
            n++;
            @(posedge clk);
            #1 binary = 8'(200 + n);
            @(negedge clk);
        end
        check("held valid ready low cycles", n, 8);
        binary = 8'd77;
        sb.push_back(77);
        @(posedge clk);
        #1 binValid = 1'b0;
        binary = 8'd0;
        @(posedge clk);
        @(negedge clk);
        check("second accept on ready edge", 32'(readyA), 0);
        check("scoreboard holds two", sb.size(), 2);
        v = (sb.size() != 0) ? sb.pop_front() : -1;
        for (int w = 0; w < 4; w++) checkNow(w, v);
        n = 0;
        while (!readyA && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("second conversion finishes", 32'(n < 50), 1);
        checkOutput();
        repeat (20) @(negedge clk);
        check("no queued accept", 32'(readyA), 1);

        // Reset four cycles into a conversion of 99
        binary   = 8'd99;
        binValid = 1'b1;
        @(posedge clk);
        sb.push_back(99);
        #1 binValid = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1 checkResetState("mid reset");
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready after reset", 32'(readyA), 1);
        sb.push_back(0);
        checkOutput();
        applyStimulus(8'd31);
        checkOutput();

        // Four-digit scan order and dwell time
        prevCa = caD;
        n = 0;
        while (caD == prevCa && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("scan change seen", 32'(n < 40), 1);
        for (int r = 0; r < 8; r++) begin
            curCa   = caD;
            prevIdx = 0;
            for (int k = 0; k < 4; k++) if (prevCa[k] == 1'b0) prevIdx = k;
            check($sformatf("scan step%0d ca", r), 32'(curCa), caMask(4, (prevIdx + 1) % 4));
            hold = 0;
            while (caD == curCa && hold < 20) begin
                hold++;
                @(negedge clk);
            end
            check($sformatf("scan step%0d dwell", r), hold, 4);
            prevCa = curCa;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seven_seg_scan_n.md
SEVEN_SEG_SCAN_N -- requirements
Module: seven_seg_scan_n

Interface
REQ-001 Parameter BIN_W, default 8, SHALL set the width of the binary input value.
REQ-002 Parameter DIGITS, default 3, SHALL set the number of multiplexed display digits (1..8).
REQ-003 Parameter PRESCALE, default 131072, SHALL set the number of clk cycles each digit stays active (>= 2).
REQ-004 Parameter BLANK_LZ, default 1, SHALL enable leading-zero blanking when 1.
REQ-005 Ports SHALL be: clk in 1, the single clock; rst_n in 1, the reset, asynchronous and active-low.
REQ-006 binary in BIN_W, unsigned value to display; bin_valid in 1, value offered.
REQ-007 bin_ready out 1, converter idle and able to accept a value.
REQ-008 seg out 7, segment pattern a..g, active-high; ca out DIGITS, one-hot digit enable, active-low, bit 0 = ones digit.
REQ-009 overflow out 1, high while the displayed value needs more than DIGITS decimal digits.

Function
REQ-010 A value SHALL be accepted on a rising clk edge with bin_valid=1 and bin_ready=1; binary is captured on that edge.
REQ-011 bin_ready SHALL be 0 from the cycle after acceptance until conversion commits; bin_valid during that time is ignored and is not queued.
REQ-012 Conversion SHALL be sequential shift-add-3 (double dabble): one shift per cycle, BIN_W cycles, over NBCD = max(DIGITS, (BIN_W+2)/3) BCD digits.
REQ-013 Commit SHALL occur BIN_W+1 cycles after the accept edge: the display register loads all DIGITS digits atomically, overflow updates and bin_ready returns to 1 in the same cycle.
REQ-014 overflow SHALL be 1 when any BCD digit at index >= DIGITS is nonzero; the display then shows '-' (segment g only) on every digit.
REQ-015 The prescaler SHALL count 0..PRESCALE-1 and wrap; on its terminal count the digit index SHALL advance 0,1,..,DIGITS-1,0.
REQ-016 seg and ca SHALL be registered and reflect the current index and display register one cycle after either changes; no cycle shows a mixed old/new digit.
REQ-017 ca SHALL drive exactly one bit low at all times after the first post-reset cycle.
REQ-018 With BLANK_LZ=1, digit i>0 SHALL show seg=0 when digits i..DIGITS-1 are all zero; digit 0 is never blanked; overflow overrides blanking.
REQ-019 seg SHALL decode BCD 0-9 to standard patterns; codes 10-15 cannot occur and SHALL decode to 0.
REQ-020 A commit coinciding with an index advance SHALL use the new display value for the new digit.

Reset
REQ-021 While rst_n=0: prescaler=0, index=0, display register=0, overflow=0, bin_ready=1, ca=all ones, seg=0.
REQ-022 Reset asserted mid-conversion SHALL abort it with no commit; after release the block accepts a new value immediately.
REQ-023 After reset release, digit 0 SHALL show '0' (ca bit0 low, seg=7'b0111111) from the second clk edge.

Structure
REQ-024 A shared package seg7_pkg SHALL hold the 7-bit patterns for 0-9, blank and '-', plus a function computing NBCD.
REQ-025 The converter SHALL be one sub-module, bin2bcd_seq (valid/ready in, done pulse and BCD vector out); scan, blanking and decode stay in seven_seg_scan_n.

Verification
REQ-026 Defaults; send 8'd207 -> bin_ready low 8 cycles, commit at accept+9, digits scan 7,0,2, ca 110,101,011, overflow=0.
REQ-027 Defaults; send 8'd5 -> digit 0 shows '5', digits 1 and 2 seg=0; repeat with BLANK_LZ=0 -> '0','0' shown.
REQ-028 DIGITS=2, BIN_W=8; send 8'd255 -> overflow=1, both digits show '-'; then send 8'd42 -> overflow=0, '4','2'.
REQ-029 Hold bin_valid high with changing binary during conversion -> only the value at the accept edge is displayed; next accept occurs on the bin_ready=1 edge.
REQ-030 Assert rst_n=0 four cycles into a conversion of 8'd99 -> outputs match REQ-021; after release display shows '0' and no 99 appears.
REQ-031 PRESCALE=4, DIGITS=4 -> ca sequence 1110,1101,1011,0111 repeating, each held exactly 4 cycles.
